// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, decoder PCSrc codes
// and the default assignment of peripherals to priority slots.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    localparam int SRC_TIMER   = 0;
    localparam int SRC_UART_RX = 1;
    localparam int SRC_UART_TX = 2;
    localparam int SRC_EXT     = 3;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: reports the index of the lowest set bit.
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int CW   = 3
) (
    input  logic [NSRC-1:0] req,
    output logic            valid,
    output logic [CW-1:0]   idx
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        valid = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = CW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Edge-captures peripheral interrupt requests, masks them, grants one by fixed
// priority and drives the decode-stage IRQ line through an assert/service handshake.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int CW    = 3,
    parameter int SVC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  SrcReq,
    input  logic             KernelMode,
    input  logic             IntAck,
    input  logic             IretDone,
    input  logic             MaskWr,
    input  logic [NSRC-1:0]  MaskWData,
    output logic             IRQ,
    output logic [CW-1:0]    IntCause,
    output logic [NSRC-1:0]  Mask,
    output logic [NSRC-1:0]  Pending,
    output logic [SVC_W-1:0] SvcCycles
);

    irq_state_t      state;
    logic [NSRC-1:0] prev_req;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] cause_bit;
    logic [NSRC-1:0] ack_clr;
    logic            sel_valid;
    logic [CW-1:0]   sel_idx;
    logic            take_ack;

    assign rise      = SrcReq & ~prev_req;
    assign eligible  = Pending & Mask;
    assign cause_bit = NSRC'(1) << IntCause;
    assign take_ack  = (state == ST_ASSERT) && IntAck;
    assign ack_clr   = take_ack ? cause_bit : '0;

    irq_prio_enc #(
        .NSRC (NSRC),
        .CW   (CW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
        if (!reset) begin
            state     <= ST_IDLE;
            prev_req  <= '0;
            Mask      <= '0;
            Pending   <= '0;
            IRQ       <= 1'b0;
            IntCause  <= '0;
            SvcCycles <= '0;
        end else begin
            prev_req <= SrcReq;
            if (MaskWr) begin
                Mask <= MaskWData;
            end
            // A new rise wins over the acknowledge clear of the same source.
            Pending <= (Pending & ~ack_clr) | rise;

            case (state)
                ST_IDLE: begin
                    if (sel_valid && !KernelMode) begin
                        IntCause <= sel_idx;
                        IRQ      <= 1'b1;
                        state    <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (IntAck) begin
                        IRQ       <= 1'b0;
                        SvcCycles <= '0;
                        state     <= ST_SERVICE;
                    end else if ((eligible & cause_bit) == '0) begin
                        IRQ   <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (SvcCycles != '1) begin
                        SvcCycles <= SvcCycles + SVC_W'(1);
                    end
                    if (IretDone) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    IRQ   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: inputs change and outputs are sampled on the
// falling edge; expected values are worked out by hand for each vector.
module tb_irq_arbiter;

    localparam int NSRC  = 4;
    localparam int CW    = 3;
    localparam int SVC_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NSRC-1:0]  SrcReq;
    logic             KernelMode;
    logic             IntAck;
    logic             IretDone;
    logic             MaskWr;
    logic [NSRC-1:0]  MaskWData;
    logic             IRQ;
    logic [CW-1:0]    IntCause;
    logic [NSRC-1:0]  Mask;
    logic [NSRC-1:0]  Pending;
    logic [SVC_W-1:0] SvcCycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    irq_arbiter #(
        .NSRC  (NSRC),
        .CW    (CW),
        .SVC_W (SVC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SrcReq     (SrcReq),
        .KernelMode (KernelMode),
        .IntAck     (IntAck),
        .IretDone   (IretDone),
        .MaskWr     (MaskWr),
        .MaskWData  (MaskWData),
        .IRQ        (IRQ),
        .IntCause   (IntCause),
        .Mask       (Mask),
        .Pending    (Pending),
        .SvcCycles  (SvcCycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then return to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_mask(input logic [NSRC-1:0] m);
        MaskWr    = 1'b1;
        MaskWData = m;
        step();
        MaskWr    = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        SrcReq     = '0;
        KernelMode = 1'b0;
        IntAck     = 1'b0;
        IretDone   = 1'b0;
        MaskWr     = 1'b0;
        MaskWData  = '0;
        @(negedge clk);
        step();
        step();
        check("rst_irq",   32'(IRQ), 32'd0);
        check("rst_cause", 32'(IntCause), 32'd0);
        check("rst_mask",  32'(Mask), 32'd0);
        check("rst_pend",  32'(Pending), 32'd0);
        check("rst_svc",   32'(SvcCycles), 32'd0);
        reset = 1'b1;

        // Basic path on source 2
        write_mask(4'b1111);
        check("mask_all", 32'(Mask), 32'hF);
        SrcReq = 4'b0100;
        step();
        SrcReq = '0;
        check("basic_pend", 32'(Pending), 32'b0100);
        check("basic_irq_lat1", 32'(IRQ), 32'd0);
        step();
        check("basic_irq", 32'(IRQ), 32'd1);
        check("basic_cause", 32'(IntCause), 32'd2);
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        check("ack_irq", 32'(IRQ), 32'd0);
        check("ack_pend", 32'(Pending), 32'd0);
        check("ack_svc0", 32'(SvcCycles), 32'd0);
        repeat (9) step();
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;
        check("svc_10", 32'(SvcCycles), 32'd10);
        step();
        check("svc_hold", 32'(SvcCycles), 32'd10);
        check("idle_irq", 32'(IRQ), 32'd0);

        // Priority: sources 1 and 3 together
        SrcReq = 4'b1010;
        step();
        SrcReq = '0;
        check("prio_pend", 32'(Pending), 32'b1010);
        step();
        check("prio_irq", 32'(IRQ), 32'd1);
        check("prio_cause1", 32'(IntCause), 32'd1);
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        check("prio_pend_left", 32'(Pending), 32'b1000);
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;
        step();
        check("prio_reirq", 32'(IRQ), 32'd1);
        check("prio_cause3", 32'(IntCause), 32'd3);

        // Higher-priority arrival in ASSERT does not preempt
        SrcReq = 4'b0001;
        step();
        SrcReq = '0;
        check("nopre_cause", 32'(IntCause), 32'd3);
        check("nopre_pend", 32'(Pending), 32'b1001);
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        check("nopre_ackpend", 32'(Pending), 32'b0001);
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;
        step();
        check("nopre_cause0", 32'(IntCause), 32'd0);
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;

        // Masking and withdraw
        write_mask(4'b0001);
        SrcReq = 4'b0100;
        step();
        SrcReq = '0;
        check("mask_pend", 32'(Pending), 32'b0100);
        step();
        check("mask_noirq", 32'(IRQ), 32'd0);
        SrcReq = 4'b0001;
        step();
        SrcReq = '0;
        step();
        check("wd_irq", 32'(IRQ), 32'd1);
        check("wd_cause", 32'(IntCause), 32'd0);
        write_mask(4'b0000);
        check("wd_irq_still", 32'(IRQ), 32'd1);
        step();
        check("wd_drop", 32'(IRQ), 32'd0);
        check("wd_pend", 32'(Pending), 32'b0101);
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        check("stray_ack_pend", 32'(Pending), 32'b0101);
        check("stray_ack_irq", 32'(IRQ), 32'd0);

        // Kernel gating, then set/clear conflict on source 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        write_mask(4'b1111);
        KernelMode = 1'b1;
        SrcReq = 4'b0001;
        step();
        SrcReq = '0;
        step();
        step();
        check("kern_block", 32'(IRQ), 32'd0);
        check("kern_pend", 32'(Pending), 32'b0001);
        KernelMode = 1'b0;
        step();
        check("kern_release", 32'(IRQ), 32'd1);
        check("kern_cause", 32'(IntCause), 32'd0);
        IntAck = 1'b1;
        SrcReq = 4'b0001;
        step();
        IntAck = 1'b0;
        SrcReq = '0;
        check("conflict_pend", 32'(Pending), 32'b0001);
        check("conflict_irq", 32'(IRQ), 32'd0);
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;
        step();
        check("conflict_reirq", 32'(IRQ), 32'd1);

        // Saturation of the service counter
        IntAck = 1'b1;
        step();
        IntAck = 1'b0;
        repeat (65600) step();
        check("svc_sat", 32'(SvcCycles), 32'hFFFF);
        IretDone = 1'b1;
        step();
        IretDone = 1'b0;
        check("svc_sat_hold", 32'(SvcCycles), 32'hFFFF);

        // Reset while in ASSERT
        SrcReq = 4'b0100;
        step();
        SrcReq = '0;
        step();
        check("pre_rst_irq", 32'(IRQ), 32'd1);
        reset = 1'b0;
        step();
        check("midrst_irq",  32'(IRQ), 32'd0);
        check("midrst_pend", 32'(Pending), 32'd0);
        check("midrst_mask", 32'(Mask), 32'd0);
        check("midrst_svc",  32'(SvcCycles), 32'd0);
        check("midrst_cause", 32'(IntCause), 32'd0);
        reset = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Collects interrupt requests from up to NSRC peripherals (timer, UART RX, UART TX, external) and drives the single IRQ input of the instruction-decode control unit. The decoder selects PCSrc=3'b100 whenever IRQ is high. The block edge-captures requests into pending bits, applies a software mask, and picks one source by fixed priority. It holds IRQ until the CPU acknowledges, then blocks further interrupts until the handler returns. It sits between the peripheral bus and the decode stage.

Parameters:
NSRC, 4, number of interrupt sources (2..8); index 0 = highest priority
CW, 3, width of IntCause (must be >= clog2(NSRC))
SVC_W, 16, width of the service-time counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low; all state is cleared on a rising clk edge with reset=0
SrcReq  in  NSRC  raw request lines from peripherals, level; only the 0->1 edge is an event
KernelMode  in  1  PC[31] of the executing instruction; 1 = in handler
IntAck  in  1  one-cycle pulse: the CPU has taken the interrupt (an instruction was issued with PCSrc=100)
IretDone  in  1  one-cycle pulse: the handler return (jr $k0 leaving kernel) has executed
MaskWr  in  1  write strobe for the mask register
MaskWData  in  NSRC  new mask value; 1 = enabled
IRQ  out  1  registered interrupt request to the control unit
IntCause  out  CW  index of the granted source; valid in ASSERT and SERVICE
Mask  out  NSRC  current mask register
Pending  out  NSRC  current pending bits
SvcCycles  out  SVC_W  cycles spent in the current or last SERVICE interval; saturating

Behaviour:
- Reset values: IRQ=0, IntCause=0, Mask=0 (all disabled), Pending=0, SvcCycles=0, prev-SrcReq register=0, state=IDLE.
- Edge capture: rise[i] = SrcReq[i] & ~prev[i], sampled each edge. A rise sets Pending[i] after the same edge. Pending is set regardless of mask.
- Mask: on MaskWr, Mask <= MaskWData after the edge. The new value takes effect for arbitration from the next cycle.
- Eligible = Pending & Mask. Sel = lowest set index of Eligible.
- States:
  - IDLE: if Eligible != 0 and KernelMode=0, then IntCause <= Sel, IRQ <= 1, go to ASSERT. Otherwise stay.
  - ASSERT: IRQ held at 1, IntCause frozen.
    - IntAck=1: IRQ <= 0, Pending[IntCause] <= 0, SvcCycles <= 0, go to SERVICE.
    - Else if (Pending & Mask)[IntCause]=0 (the source was masked): IRQ <= 0, go to IDLE (withdraw).
  - SERVICE: IRQ=0, SvcCycles increments every cycle and saturates at all-ones. IretDone=1 goes to IDLE; SvcCycles keeps its last value.
- IntAck outside ASSERT and IretDone outside SERVICE are ignored; no state change.
- Latency: SrcReq rise first sampled at edge k -> Pending set after k -> IRQ=1 after k+1, provided the state is IDLE, the source is enabled and KernelMode=0.
- Set/clear conflict: if a rise on source i and its IntAck clear land on the same edge, the set wins and Pending[i] stays 1 (a new event).
- Rises during SERVICE are latched and served after IretDone; IRQ may re-assert the cycle after the IDLE return.
- KernelMode=1 in IDLE blocks assertion. KernelMode has no effect once in ASSERT.
- Higher-priority events arriving in ASSERT do not preempt; IntCause stays frozen until ack or withdraw.
- Reset mid-operation (any state) returns everything to reset values on that edge. Pending events are lost.

Decomposition:
- Shared package irq_pkg: state encoding (IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2), PCSRC_IRQ=3'b100, PCSRC_EXC=3'b101, default source indices (SRC_TIMER=0, SRC_UART_RX=1, SRC_UART_TX=2, SRC_EXT=3).
- One sub-module, irq_prio_enc: a combinational fixed-priority encoder. Input NSRC-bit vector; outputs a valid flag and the CW-bit index of the lowest set bit.

Test Plan:
- Basic path: reset 2 cycles, Mask=4'b1111, pulse SrcReq[2] -> IRQ=1 exactly 2 edges after the rise, IntCause=2. IntAck -> IRQ=0 and Pending=0 next cycle. IretDone after 10 cycles -> IDLE, SvcCycles=10.
- Priority: SrcReq[3] and SrcReq[1] rise on the same edge -> IntCause=1. After ack and IretDone, IRQ re-asserts with IntCause=3.
- Masking and withdraw: Mask=4'b0001, rise on source 2 -> Pending=4'b0100, IRQ stays 0. In ASSERT for source 0, write Mask=0 -> IRQ drops the next cycle, state returns to IDLE, Pending[0] still 1.
- Kernel gating and conflicts: KernelMode=1 with Eligible!=0 -> IRQ stays 0 until KernelMode=0. A rise on source 0 on the same edge as IntAck for source 0 -> Pending[0]=1 after that edge.
- Saturation and reset: hold SERVICE for 70000 cycles with SVC_W=16 -> SvcCycles=16'hFFFF. Assert reset=0 in ASSERT -> IRQ, Pending, Mask and SvcCycles are all 0 after the edge.
